// File: rtl/sram_row_sequencer_if.sv
// Signal bundle between the row sequencer and its SDRAM, SRAM and window-buffer neighbours.
interface sram_row_sequencer_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WIDTH_W = 13
);
    // Row control
    logic               start;
    logic [WIDTH_W-1:0] image_width;
    logic               busy;
    logic               done;

    // Address calculator control
    logic               addr_mode;
    logic               addr_enable;
    logic               addr_clear;

    // SRAM port
    logic               sram_read_en;
    logic               sram_write_en;
    logic [DATA_W-1:0]  sram_wdata;
    logic [DATA_W-1:0]  sram_rdata;

    // SDRAM -> block pixel stream
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_ready;

    // Block -> window buffer pixel stream
    logic               wb_valid;
    logic [DATA_W-1:0]  wb_data;

    // Window buffer -> block result stream
    logic               res_valid;
    logic [DATA_W-1:0]  res_data;

    // Block -> SDRAM result stream
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_ready;

    // Sequencer side
    modport master (
        input  start, image_width, sram_rdata,
        input  in_valid, in_data, res_valid, res_data, out_ready,
        output busy, done, addr_mode, addr_enable, addr_clear,
        output sram_read_en, sram_write_en, sram_wdata,
        output in_ready, wb_valid, wb_data, out_valid, out_data
    );

    // Environment side
    modport slave (
        output start, image_width, sram_rdata,
        output in_valid, in_data, res_valid, res_data, out_ready,
        input  busy, done, addr_mode, addr_enable, addr_clear,
        input  sram_read_en, sram_write_en, sram_wdata,
        input  in_ready, wb_valid, wb_data, out_valid, out_data
    );
endinterface

// File: rtl/sram_row_sequencer.sv
// Per-row transfer sequencer: SDRAM -> row cache -> window buffer, results -> output region -> SDRAM.
module sram_row_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WIDTH_W = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_row_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        FEED    = 3'd2,
        COLLECT = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state;
    logic [WIDTH_W-1:0] w;
    logic [WIDTH_W-1:0] cnt;
    logic               addr_clear_q;
    logic               wb_valid_q;
    logic               rd_pending;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;

    logic               in_beat;
    logic               res_beat;
    logic               feed_rd;
    logic               drain_rd;
    logic               drain_hs;

    // Per-cycle transfer events decoded from state and the stream inputs.
    always_comb begin
        in_beat  = (state == LOAD) && bus.in_valid;
        res_beat = (state == COLLECT) && bus.res_valid;
        // FEED issues one read per cycle for the first W cycles; the last cycle only returns data.
        feed_rd  = (state == FEED) && (cnt != w);
        // DRAIN keeps a single read in flight and waits for the held word to leave.
        drain_rd = (state == DRAIN) && !rd_pending && !out_valid_q;
        drain_hs = (state == DRAIN) && out_valid_q && bus.out_ready;
    end

    // Status and address-calculator control.
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.addr_mode  = !((state == COLLECT) || (state == DRAIN));
    assign bus.addr_clear = addr_clear_q;
    assign bus.in_ready   = (state == LOAD);

    // SRAM strobes: writes follow accepted stream beats in the same cycle, reads come from FEED/DRAIN.
    assign bus.sram_write_en = in_beat || res_beat;
    assign bus.sram_read_en  = feed_rd || drain_rd;
    assign bus.addr_enable   = in_beat || res_beat || feed_rd || drain_rd;
    assign bus.sram_wdata    = in_beat  ? bus.in_data  :
                               res_beat ? bus.res_data : '0;

    // SRAM read data is already a register stage; forward it only while its FEED read is returning.
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_data  = wb_valid_q ? bus.sram_rdata : '0;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Row state machine, beat counter and registered stream flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            w            <= '0;
            cnt          <= '0;
            addr_clear_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            rd_pending   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            addr_clear_q <= 1'b0;
            wb_valid_q   <= feed_rd;
            rd_pending   <= drain_rd;

            case (state)
                IDLE: begin
                    if (bus.start && (bus.image_width != '0)) begin
                        w            <= bus.image_width;
                        cnt          <= '0;
                        addr_clear_q <= 1'b1;
                        state        <= LOAD;
                    end
                end

                LOAD: begin
                    if (in_beat) begin
                        if (cnt == w - WIDTH_W'(1)) begin
                            cnt   <= '0;
                            state <= FEED;
                        end else begin
                            cnt <= cnt + WIDTH_W'(1);
                        end
                    end
                end

                FEED: begin
                    // cnt == w is the cycle carrying the last window-buffer beat.
                    if (cnt == w) begin
                        cnt   <= '0;
                        state <= (w == WIDTH_W'(1)) ? DONE : COLLECT;
                    end else begin
                        cnt <= cnt + WIDTH_W'(1);
                    end
                end

                COLLECT: begin
                    if (res_beat) begin
                        if (cnt == w - WIDTH_W'(2)) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + WIDTH_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (rd_pending) begin
                        out_data_q  <= bus.sram_rdata;
                        out_valid_q <= 1'b1;
                    end
                    if (drain_hs) begin
                        out_valid_q <= 1'b0;
                        if (cnt == w - WIDTH_W'(2)) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + WIDTH_W'(1);
                        end
                    end
                end

                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_row_sequencer.sv
// Randomized self-checking bench for sram_row_sequencer with SRAM, address-calculator and stream models.
module tb_sram_row_sequencer;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned WIDTH_W   = 13;
    localparam int          MEM_DEPTH = 16384;
    localparam logic [13:0] RC_BASE   = 14'd0;
    localparam logic [13:0] OUT_BASE  = 14'd8192;
    localparam int          GUARD     = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sram_row_sequencer_if #(.DATA_W(DATA_W), .WIDTH_W(WIDTH_W)) bus ();

    sram_row_sequencer #(.DATA_W(DATA_W), .WIDTH_W(WIDTH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // SRAM plus a stand-in for sram_address_calc: per region, independent write and read pointers,
    // all reset by clear, with clear taking effect before enable in the same cycle.
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [13:0]       rc_w, rc_r, oc_w, oc_r;
    logic [13:0]       sram_addr;

    always_comb begin
        if (bus.addr_clear)
            sram_addr = bus.addr_mode ? RC_BASE : OUT_BASE;
        else if (bus.addr_mode)
            sram_addr = bus.sram_write_en ? rc_w : rc_r;
        else
            sram_addr = bus.sram_write_en ? oc_w : oc_r;
    end

    always @(posedge clk) begin
        if (rst) bus.sram_rdata <= '0;
        else if (bus.sram_read_en) bus.sram_rdata <= mem[sram_addr];
        if (bus.sram_write_en) mem[sram_addr] <= bus.sram_wdata;
        if (bus.addr_clear) begin
            rc_w <= RC_BASE;  rc_r <= RC_BASE;
            oc_w <= OUT_BASE; oc_r <= OUT_BASE;
        end
        if (bus.addr_enable) begin
            if (bus.addr_mode) begin
                if (bus.sram_write_en) rc_w <= sram_addr + 14'd1;
                else                   rc_r <= sram_addr + 14'd1;
            end else begin
                if (bus.sram_write_en) oc_w <= sram_addr + 14'd1;
                else                   oc_r <= sram_addr + 14'd1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Control outputs packed {busy,done,addr_mode,addr_enable,addr_clear,rd,wr,in_ready,wb_valid,out_valid}.
    function automatic logic [31:0] ctl_vec();
        return 32'({bus.busy, bus.done, bus.addr_mode, bus.addr_enable, bus.addr_clear,
                    bus.sram_read_en, bus.sram_write_en, bus.in_ready, bus.wb_valid, bus.out_valid});
    endfunction

    function automatic logic [31:0] data_vec();
        return 32'({bus.sram_wdata, bus.wb_data, bus.out_data});
    endfunction

    localparam logic [31:0] CTL_RESET = 32'h080;

    // Per-row reference data and observations.
    logic [DATA_W-1:0] p_q[$];
    logic [DATA_W-1:0] r_q[$];
    logic [DATA_W-1:0] wb_q[$];
    logic [DATA_W-1:0] out_q[$];
    int en_cnt, clr_cnt, done_cnt, rd1, wr1, rd0, wr0;
    int excl_bad, hold_bad, wb_gap, wb_total, busy_drop, lat;

    // SDRAM source: mode 0 continuous, 1 toggling, 2 random.
    task automatic drive_src(input int n, input int mode);
        int i = 0;
        int t = 0;
        while (i < n && t < GUARD) begin
            case (mode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (t % 2 == 0);
                default: bus.in_valid = 1'($urandom);
            endcase
            bus.in_data = p_q[i];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            @(posedge clk); #1;
            t++;
        end
        bus.in_valid = 1'($urandom);
        bus.in_data  = DATA_W'($urandom);
        if (i < n) check("src_timeout", 32'(i), 32'(n));
    endtask

    // Window buffer: junk results until the pixel stream completes, then the row's results.
    task automatic wb_side(input int n, input int mode);
        int seen = 0;
        int j = 0;
        int t = 0;
        while (seen < n && t < GUARD) begin
            bus.res_valid = 1'($urandom);
            bus.res_data  = DATA_W'($urandom);
            @(negedge clk);
            if (bus.wb_valid) begin
                wb_q.push_back(bus.wb_data);
                seen++;
            end else if (seen > 0) begin
                wb_gap++;
            end
            @(posedge clk); #1;
            t++;
        end
        if (seen < n) check("wb_timeout", 32'(seen), 32'(n));
        while (j < n - 1 && t < GUARD) begin
            bus.res_valid = (mode == 0) ? 1'b1 : 1'($urandom);
            bus.res_data  = r_q[j];
            @(posedge clk); #1;
            if (bus.res_valid) j++;
            t++;
        end
        bus.res_valid = 1'($urandom);
        bus.res_data  = DATA_W'($urandom);
    endtask

    // SDRAM sink: mode 0 always ready, 1 holds ready low 4 cycles per word, 2 random.
    task automatic sink(input int n, input int mode);
        int got = 0;
        int stall = 0;
        int t = 0;
        bit held = 1'b0;
        logic [DATA_W-1:0] held_d = '0;
        while (got < n - 1 && t < GUARD) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (stall >= 4);
                default: bus.out_ready = 1'($urandom);
            endcase
            @(negedge clk);
            if (held && (!bus.out_valid || bus.out_data !== held_d)) hold_bad++;
            held = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                out_q.push_back(bus.out_data);
                got++;
                stall = 0;
            end else if (bus.out_valid) begin
                stall++;
                held   = 1'b1;
                held_d = bus.out_data;
            end
            @(posedge clk); #1;
            t++;
        end
        bus.out_ready = 1'($urandom);
        if (got < n - 1) check("sink_timeout", 32'(got), 32'(n - 1));
    endtask

    // Strobe and status monitor from the first LOAD cycle until done.
    task automatic watch();
        int t = 0;
        bit fin = 1'b0;
        while (!fin && t < GUARD) begin
            @(negedge clk);
            t++;
            if (bus.addr_enable) en_cnt++;
            if (bus.addr_clear) clr_cnt++;
            if (bus.sram_read_en && bus.sram_write_en) excl_bad++;
            if (bus.addr_enable && !(bus.sram_read_en || bus.sram_write_en)) excl_bad++;
            if (bus.sram_read_en)  begin if (bus.addr_mode) rd1++; else rd0++; end
            if (bus.sram_write_en) begin if (bus.addr_mode) wr1++; else wr0++; end
            if (bus.wb_valid) wb_total++;
            if (!bus.busy) busy_drop++;
            if (bus.done) begin
                done_cnt++;
                lat = t + 1;
                fin = 1'b1;
            end
        end
        if (!fin) check("done_timeout", 32'(0), 32'(1));
    endtask

    // Pulse start during FEED of a continuously fed row; it must be ignored.
    task automatic poke(input int n);
        repeat (n + 1) @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.image_width = WIDTH_W'(3);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_row(input int w, input int in_mode, input int res_mode, input int rdy_mode,
                           input bit poke_start, input bit seq_data);
        bit cont;
        p_q.delete(); r_q.delete(); wb_q.delete(); out_q.delete();
        for (int i = 0; i < w; i++)
            p_q.push_back(seq_data ? DATA_W'(10 + i) : DATA_W'($urandom));
        for (int i = 0; i < w - 1; i++)
            r_q.push_back(DATA_W'($urandom));
        en_cnt = 0; clr_cnt = 0; done_cnt = 0; rd1 = 0; wr1 = 0; rd0 = 0; wr0 = 0;
        excl_bad = 0; hold_bad = 0; wb_gap = 0; wb_total = 0; busy_drop = 0; lat = 0;

        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.image_width = WIDTH_W'(w);
        @(negedge clk);
        check("idle_before_start", ctl_vec() & 32'h300, 32'h0);
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.image_width = WIDTH_W'($urandom);

        fork
            drive_src(w, in_mode);
            wb_side(w, res_mode);
            sink(w, rdy_mode);
            watch();
            if (poke_start) poke(w);
        join

        check($sformatf("w%0d wb_count", w), 32'(wb_q.size()), 32'(w));
        for (int i = 0; i < w && i < wb_q.size(); i++)
            check($sformatf("w%0d wb_data[%0d]", w, i), 32'(wb_q[i]), 32'(p_q[i]));
        check($sformatf("w%0d out_count", w), 32'(out_q.size()), 32'(w - 1));
        for (int i = 0; i < w - 1 && i < out_q.size(); i++)
            check($sformatf("w%0d out_data[%0d]", w, i), 32'(out_q[i]), 32'(r_q[i]));
        for (int i = 0; i < w; i++)
            check($sformatf("w%0d row_cache[%0d]", w, i), 32'(mem[RC_BASE + 14'(i)]), 32'(p_q[i]));
        for (int i = 0; i < w - 1; i++)
            check($sformatf("w%0d out_region[%0d]", w, i), 32'(mem[OUT_BASE + 14'(i)]), 32'(r_q[i]));
        check($sformatf("w%0d addr_enable_count", w), 32'(en_cnt), 32'(4 * w - 2));
        check($sformatf("w%0d addr_clear_count", w), 32'(clr_cnt), 32'(1));
        check($sformatf("w%0d done_count", w), 32'(done_cnt), 32'(1));
        check($sformatf("w%0d cache_writes", w), 32'(wr1), 32'(w));
        check($sformatf("w%0d cache_reads", w), 32'(rd1), 32'(w));
        check($sformatf("w%0d out_writes", w), 32'(wr0), 32'(w - 1));
        check($sformatf("w%0d out_reads", w), 32'(rd0), 32'(w - 1));
        check($sformatf("w%0d strobe_exclusion", w), 32'(excl_bad), 32'(0));
        check($sformatf("w%0d out_hold", w), 32'(hold_bad), 32'(0));
        check($sformatf("w%0d wb_gaps", w), 32'(wb_gap), 32'(0));
        check($sformatf("w%0d wb_total", w), 32'(wb_total), 32'(w));
        check($sformatf("w%0d busy_drop", w), 32'(busy_drop), 32'(0));
        cont = (in_mode == 0) && (res_mode == 0) && (rdy_mode == 0);
        if (cont) check($sformatf("w%0d row_latency", w), 32'(lat), 32'(6 * w - 1));
    endtask

    // Start a W=6 row with continuous input, reset it asynchronously during COLLECT.
    task automatic reset_mid_row();
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.image_width = WIDTH_W'(6);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = DATA_W'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.res_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        bus.res_valid = 1'b1;
        bus.res_data  = DATA_W'($urandom);
        @(posedge clk); #1;
        bus.res_data  = DATA_W'($urandom);
        @(negedge clk);
        check("collect_mode_before_reset", 32'(bus.addr_mode), 32'(0));
        check("collect_write_before_reset", 32'(bus.sram_write_en), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("ctl_after_async_reset", ctl_vec(), CTL_RESET);
        check("data_after_async_reset", data_vec(), 32'h0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.res_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int w0_bad;
        bus.start       = 1'b0;
        bus.image_width = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.res_valid   = 1'b0;
        bus.res_data    = '0;
        bus.out_ready   = 1'b0;

        // Reset values while held and after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ctl_in_reset", ctl_vec(), CTL_RESET);
        check("data_in_reset", data_vec(), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ctl_after_release", ctl_vec(), CTL_RESET);

        // Reset asserted while idle.
        #2 rst = 1'b1;
        #1 check("ctl_idle_reset", ctl_vec(), CTL_RESET);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic row with data 10..13 and continuous streams.
        run_row(4, 0, 0, 0, 1'b0, 1'b1);
        // Stalled input and output.
        run_row(5, 1, 0, 1, 1'b0, 1'b0);
        // Degenerate single-pixel row.
        run_row(1, 0, 0, 0, 1'b0, 1'b0);

        // Zero width start is ignored.
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.image_width = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        w0_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.addr_clear || bus.in_ready) w0_bad++;
        end
        check("zero_width_ignored", 32'(w0_bad), 32'(0));

        // Start pulsed during FEED, junk results during LOAD.
        run_row(7, 0, 0, 0, 1'b1, 1'b0);

        // Asynchronous reset in COLLECT, then a clean W=3 row.
        reset_mid_row();
        run_row(3, 0, 0, 0, 1'b0, 1'b0);

        // Wide rows back to back.
        run_row(50, 0, 0, 0, 1'b0, 1'b0);
        run_row(50, 0, 0, 0, 1'b0, 1'b0);

        // Random widths and random stream behaviour.
        for (int k = 0; k < 4; k++)
            run_row(int'($urandom_range(1, 20)), 2, 2, 2, 1'b0, 1'b0);

        @(posedge clk); #1;
        @(negedge clk);
        check("idle_at_end", ctl_vec() & 32'h300, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
